quad_decoder_counter: RTL and testbench



---
 rtl/quad_decoder_counter.sv | 178 +++++++++++++++++
 tb/tb_quad_decoder_counter.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/quad_decoder_counter.sv
// ---------------------------------------------------------------------------
// quad_decoder_counter
//   Quadrature decoder. Two asynchronous phase inputs are synchronized,
//   optionally glitch-filtered, and decoded into one-cycle up/down step
//   strobes. A wrapping position count follows the strobes. Transitions
//   where both phases change at once set a sticky error flag.
//
//   Optional feature macro: QUAD_FILTER_EN
//     When defined, each phase has a glitch filter after its synchronizer.
//     A new level is accepted only after FILTER_LEN consecutive cycles.
//
// Ports:
//   clk      in   system clock, rising edge
//   reset    in   asynchronous, active-high reset
//   t        in   count enable (decode continues when low)
//   quad_a   in   phase A, asynchronous
//   quad_b   in   phase B, asynchronous
//   err_clr  in   synchronous clear of err
//   up       out  one-cycle strobe per forward step
//   down     out  one-cycle strobe per reverse step
//   q        out  [WIDTH-1:0] position count, wraps mod 2^WIDTH
//   err      out  sticky illegal-transition flag
// ---------------------------------------------------------------------------

// Per-phase front end: synchronizer plus optional glitch filter.
//   run  : synchronizer has been filled since reset
//   dout : level presented to the decoder
//   dvld : dout holds a real (not reset-default) value
module qdc_phase #(
   parameter int SYNC_STAGES = 2,
   parameter int FILTER_LEN  = 3
) (
   input  logic clk,
   input  logic reset,
   input  logic run,
   input  logic din,
   output logic dout,
   output logic dvld
);
   if (SYNC_STAGES < 2 || FILTER_LEN < 1) begin : g_param_chk
      $error("qdc_phase: SYNC_STAGES must be >= 2 and FILTER_LEN >= 1");
   end

   logic [SYNC_STAGES-1:0] sync;
   logic                   sa;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) sync <= '0;
      else       sync <= {sync[SYNC_STAGES-2:0], din};
   end

   assign sa = sync[SYNC_STAGES-1];

`ifdef QUAD_FILTER_EN
   localparam int CW = $clog2(FILTER_LEN + 1);

   logic          cand;     // previous synchronized sample
   logic [CW-1:0] hold;     // consecutive cycles sa has matched cand
   logic [CW-1:0] hold_nxt;
   logic          fout;
   logic          fvld;

   // Saturating run-length of the current synchronized level.
   always_comb begin
      hold_nxt = hold;
      if (sa != cand)                  hold_nxt = CW'(1);
      else if (hold != CW'(FILTER_LEN)) hold_nxt = hold + CW'(1);
   end

   // The filter is held idle until the synchronizer carries real pin data,
   // so reset zeros in the sync chain are never accepted as a level.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cand <= 1'b0;
         hold <= '0;
         fout <= 1'b0;
         fvld <= 1'b0;
      end else if (run) begin
         cand <= sa;
         hold <= hold_nxt;
         if (hold_nxt == CW'(FILTER_LEN)) begin
            fout <= sa;
            fvld <= 1'b1;
         end
      end
   end

   assign dout = fout;
   assign dvld = fvld;
`else
   assign dout = sa;
   assign dvld = run;
`endif
endmodule

module quad_decoder_counter #(
   parameter int WIDTH       = 4,
   parameter int SYNC_STAGES = 2,
   parameter int FILTER_LEN  = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             t,
   input  logic             quad_a,
   input  logic             quad_b,
   input  logic             err_clr,
   output logic             up,
   output logic             down,
   output logic [WIDTH-1:0] q,
   output logic             err
);
   // Bit 1 is phase A, bit 0 is phase B throughout.
   logic [1:0]             pins;
   logic [1:0]             dec_ab;
   logic [1:0]             dvld;
   logic [1:0]             prev_ab;
   logic                   primed;
   // vld_pipe[i] is set once i+1 edges have passed since reset release.
   logic [SYNC_STAGES-1:0] vld_pipe;
   logic                   fwd, rev, ill;

   assign pins = {quad_a, quad_b};

   for (genvar g = 0; g < 2; g++) begin : g_ph
      qdc_phase #(
         .SYNC_STAGES (SYNC_STAGES),
         .FILTER_LEN  (FILTER_LEN)
      ) u_ph (
         .clk   (clk),
         .reset (reset),
         .run   (vld_pipe[SYNC_STAGES-1]),
         .din   (pins[g]),
         .dout  (dec_ab[g]),
         .dvld  (dvld[g])
      );
   end

   // Gray-code successors: forward {a,b} -> {b,~a}, reverse {a,b} -> {~b,a}.
   // Both bits flipping is the only remaining change and is illegal.
   assign fwd = (dec_ab == {prev_ab[0], ~prev_ab[1]});
   assign rev = (dec_ab == {~prev_ab[0], prev_ab[1]});
   assign ill = &(dec_ab ^ prev_ab);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         vld_pipe <= '0;
         primed   <= 1'b0;
         prev_ab  <= 2'b00;
         up       <= 1'b0;
         down     <= 1'b0;
         q        <= '0;
         err      <= 1'b0;
      end else begin
         vld_pipe <= {vld_pipe[SYNC_STAGES-2:0], 1'b1};
         up       <= 1'b0;
         down     <= 1'b0;
         err      <= err & ~err_clr;
         if (!primed) begin
            // First real sample becomes the reference; never a step.
            if (vld_pipe[SYNC_STAGES-1] && (&dvld)) begin
               primed  <= 1'b1;
               prev_ab <= dec_ab;
            end
         end else begin
            prev_ab <= dec_ab;
            if (ill) begin
               err <= 1'b1;                 // set wins over err_clr
            end else if (t && fwd) begin
               up <= 1'b1;
               q  <= q + WIDTH'(1);
            end else if (t && rev) begin
               down <= 1'b1;
               q    <= q - WIDTH'(1);
            end
         end
      end
   end
endmodule

// File: tb/tb_quad_decoder_counter.sv
// ---------------------------------------------------------------------------
// tb_quad_decoder_counter
//   Directed bench for quad_decoder_counter at default parameters
//   (WIDTH=4, SYNC_STAGES=2), filter disabled. Expected values are written
//   by hand into each vector.
// ---------------------------------------------------------------------------
module tb_quad_decoder_counter;
   logic       clk = 1'b0;
   logic       reset, t, quad_a, quad_b, err_clr;
   logic       up, down, err;
   logic [3:0] q;

   int n_cmp = 0;
   int n_bad = 0;

   quad_decoder_counter dut (
      .clk     (clk),
      .reset   (reset),
      .t       (t),
      .quad_a  (quad_a),
      .quad_b  (quad_b),
      .err_clr (err_clr),
      .up      (up),
      .down    (down),
      .q       (q),
      .err     (err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Drive one pin transition and watch the 4 following cycles. The strobe
   // and q update are due on the 3rd edge (pin change sets up for edge N,
   // result registered on edge N+2).
   task automatic xfer(input logic [1:0] ab, input logic eu, input logic ed,
                       input logic [3:0] qb, input logic [3:0] qa, input logic ee);
      {quad_a, quad_b} = ab;
      tick; chk("lat0", 32'({up, down, q}), 32'({2'b00, qb}));
      tick; chk("lat1", 32'({up, down, q}), 32'({2'b00, qb}));
      tick; chk("step", 32'({up, down, q}), 32'({eu, ed, qa}));
            chk("step_err", 32'(err), 32'(ee));
      tick; chk("post", 32'({up, down, q}), 32'({2'b00, qa}));
            chk("post_err", 32'(err), 32'(ee));
   endtask

   initial begin
      reset = 1'b1; t = 1'b1; quad_a = 1'b0; quad_b = 1'b0; err_clr = 1'b0;
      tick; tick;
      chk("rst_vals", 32'({up, down, err, q}), 32'(0));
      reset = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick; chk("prime00", 32'({up, down, err, q}), 32'(0));
      end

      // forward 00->01->11->10->00
      xfer(2'b01, 1'b1, 1'b0, 4'h0, 4'h1, 1'b0);
      xfer(2'b11, 1'b1, 1'b0, 4'h1, 4'h2, 1'b0);
      xfer(2'b10, 1'b1, 1'b0, 4'h2, 4'h3, 1'b0);
      xfer(2'b00, 1'b1, 1'b0, 4'h3, 4'h4, 1'b0);

      // reverse 6 steps with wrap through 0
      xfer(2'b10, 1'b0, 1'b1, 4'h4, 4'h3, 1'b0);
      xfer(2'b11, 1'b0, 1'b1, 4'h3, 4'h2, 1'b0);
      xfer(2'b01, 1'b0, 1'b1, 4'h2, 4'h1, 1'b0);
      xfer(2'b00, 1'b0, 1'b1, 4'h1, 4'h0, 1'b0);
      xfer(2'b10, 1'b0, 1'b1, 4'h0, 4'hF, 1'b0);
      xfer(2'b11, 1'b0, 1'b1, 4'hF, 4'hE, 1'b0);

      // to 01, then illegal jump 01->10
      xfer(2'b01, 1'b0, 1'b1, 4'hE, 4'hD, 1'b0);
      xfer(2'b10, 1'b0, 1'b0, 4'hD, 4'hD, 1'b1);
      err_clr = 1'b1; tick; chk("err_clr", 32'(err), 32'(0));
      err_clr = 1'b0;

      // illegal 10->01 with err_clr on the same edge: set wins
      {quad_a, quad_b} = 2'b01;
      tick; tick;
      err_clr = 1'b1;
      tick; chk("set_wins", 32'(err), 32'(1));
            chk("set_wins_q", 32'({up, down, q}), 32'({2'b00, 4'hD}));
      err_clr = 1'b0;
      tick; chk("set_wins_hold", 32'(err), 32'(1));
      err_clr = 1'b1; tick; chk("err_clr2", 32'(err), 32'(0));
      err_clr = 1'b0;

      // enable low: decode tracks but nothing counts
      t = 1'b0;
      xfer(2'b11, 1'b0, 1'b0, 4'hD, 4'hD, 1'b0);
      xfer(2'b10, 1'b0, 1'b0, 4'hD, 4'hD, 1'b0);
      xfer(2'b00, 1'b0, 1'b0, 4'hD, 4'hD, 1'b0);
      t = 1'b1;
      xfer(2'b01, 1'b1, 1'b0, 4'hD, 4'hE, 1'b0);

      // reset with pins at 11: async clear, then quiet priming
      reset = 1'b1; {quad_a, quad_b} = 2'b11;
      #1 chk("rst_async_a", 32'({up, down, err, q}), 32'(0));
      tick; tick;
      reset = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick; chk("prime11", 32'({up, down, err, q}), 32'(0));
      end

      // illegal 11->00 sets err, then count up to 6
      xfer(2'b00, 1'b0, 1'b0, 4'h0, 4'h0, 1'b1);
      xfer(2'b01, 1'b1, 1'b0, 4'h0, 4'h1, 1'b1);
      xfer(2'b11, 1'b1, 1'b0, 4'h1, 4'h2, 1'b1);
      xfer(2'b10, 1'b1, 1'b0, 4'h2, 4'h3, 1'b1);
      xfer(2'b00, 1'b1, 1'b0, 4'h3, 4'h4, 1'b1);
      xfer(2'b01, 1'b1, 1'b0, 4'h4, 4'h5, 1'b1);
      xfer(2'b11, 1'b1, 1'b0, 4'h5, 4'h6, 1'b1);

      // step to 7, then reset mid-cycle while up is high
      {quad_a, quad_b} = 2'b10;
      tick; tick; tick;
      chk("q7", 32'({up, down, err, q}), 32'({1'b1, 1'b0, 1'b1, 4'h7}));
      #2 reset = 1'b1;
      #1 chk("rst_async_b", 32'({up, down, err, q}), 32'(0));
      {quad_a, quad_b} = 2'b00;        // in flight when reset releases
      tick;
      reset = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick; chk("prime_rst", 32'({up, down, err, q}), 32'(0));
      end
      xfer(2'b01, 1'b1, 1'b0, 4'h0, 4'h1, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
